// File: rtl/vec_add_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vec_add_pkg                                                     |
// | Purpose  : Shared defaults, FSM state encoding and lane-vector type for    |
// |            the vec_add_sched shared lane-wise adder.                       |
// | Config   : VEC_ADD_SAT_EN (consumed by vec_lane_add)                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package vec_add_pkg;

  localparam int C_LANE_W = 8;
  localparam int C_LANES  = 3;
  localparam int C_DW     = C_LANE_W * C_LANES;

  // Controller sequence, one state per cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // One lane and a packed vector of lanes at the default geometry.
  typedef logic [C_LANE_W-1:0]    lane_t;
  typedef lane_t [C_LANES-1:0]    lane_vec_t;

endpackage
`default_nettype wire

// File: rtl/vec_lane_add.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vec_lane_add                                                    |
// | Purpose  : Combinational LANES-lane adder, no carry between lanes.         |
// |            Each lane's carry-out is reported on carry[lane].               |
// | Config   : VEC_ADD_SAT_EN defined -> a lane with carry-out saturates to    |
// |            all-ones; undefined -> lanes wrap modulo 2^LANE_W.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module vec_lane_add
  import vec_add_pkg::*;
#(
  parameter int LANE_W = C_LANE_W,
  parameter int LANES  = C_LANES,
  localparam int DW    = LANE_W * LANES
) (
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic [DW-1:0]    sum,
  output logic [LANES-1:0] carry
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    // One extra bit per lane captures the carry-out without touching the neighbour.
    logic [LANE_W:0] w_ext;
    assign w_ext     = {1'b0, a[LANE_W*gi +: LANE_W]} + {1'b0, b[LANE_W*gi +: LANE_W]};
    assign carry[gi] = w_ext[LANE_W];
`ifdef VEC_ADD_SAT_EN
    assign sum[LANE_W*gi +: LANE_W] = w_ext[LANE_W] ? {LANE_W{1'b1}} : w_ext[LANE_W-1:0];
`else
    assign sum[LANE_W*gi +: LANE_W] = w_ext[LANE_W-1:0];
`endif
  end : g_lane

endmodule
`default_nettype wire

// File: rtl/vec_add_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vec_add_sched                                                   |
// | Purpose  : Shares one lane-wise vector adder between two requesters.       |
// |            IDLE (arbitrate) -> LOAD (latch operands) -> EXEC (add) ->      |
// |            DONE (count, flip priority) -> IDLE; ack pulses one cycle.      |
// | Config   : VEC_ADD_SAT_EN selects saturating lanes in vec_lane_add.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module vec_add_sched
  import vec_add_pkg::*;
#(
  parameter int LANE_W = C_LANE_W,
  parameter int LANES  = C_LANES,
  parameter int CNT_W  = 16,
  localparam int DW    = LANE_W * LANES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_i,
  input  logic [DW-1:0]    a0_i,
  input  logic [DW-1:0]    b0_i,
  input  logic [DW-1:0]    a1_i,
  input  logic [DW-1:0]    b1_i,
  output logic [1:0]       ack_o,
  output logic [DW-1:0]    res_o,
  output logic [LANES-1:0] ovf_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] op_cnt_o
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_grant;   // index of the requester being served
  logic             r_ptr;     // requester that wins a tie
  logic             w_pick;
  logic [DW-1:0]    r_a;
  logic [DW-1:0]    r_b;
  logic [DW-1:0]    r_res;
  logic [LANES-1:0] r_ovf;
  logic [1:0]       r_ack;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    w_sum;
  logic [LANES-1:0] w_carry;

  vec_lane_add #(
    .LANE_W (LANE_W),
    .LANES  (LANES)
  ) u_add (
    .a     (r_a),
    .b     (r_b),
    .sum   (w_sum),
    .carry (w_carry)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state sequencing and arbitration: a lone requester wins, a tie goes to r_ptr.
  always_comb begin
    w_state_nxt = r_state;
    w_pick      = r_ptr;
    if (req_i == 2'b01)      w_pick = 1'b0;
    else if (req_i == 2'b10) w_pick = 1'b1;
    case (r_state)
      ST_IDLE: if (req_i != 2'b00) w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: grant capture, operand latch, result capture, ack pulse and counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grant <= 1'b0;
      r_ptr   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_ovf   <= '0;
      r_ack   <= 2'b00;
      r_cnt   <= '0;
    end else begin
      r_ack <= 2'b00;
      case (r_state)
        ST_IDLE: if (req_i != 2'b00) r_grant <= w_pick;
        ST_LOAD: begin
          r_a <= r_grant ? a1_i : a0_i;
          r_b <= r_grant ? b1_i : b0_i;
        end
        ST_EXEC: begin
          r_res <= w_sum;
          r_ovf <= w_carry;
        end
        ST_DONE: begin
          r_ack <= r_grant ? 2'b10 : 2'b01;
          r_cnt <= r_cnt + C_CNT_ONE;
          r_ptr <= ~r_grant;
        end
        default: ;
      endcase
    end
  end

  assign ack_o    = r_ack;
  assign res_o    = r_res;
  assign ovf_o    = r_ovf;
  assign busy_o   = (r_state != ST_IDLE);
  assign op_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vec_add_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vec_add_sched                                                |
// | Purpose  : Self-checking bench for vec_add_sched (CNT_W=4 so the counter   |
// |            wraps after 16 operations).                                     |
// | Config   : VEC_ADD_SAT_EN switches expected lane results to saturation.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_vec_add_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_i;
  logic [23:0] a0_i, b0_i, a1_i, b1_i;
  logic [1:0]  ack_o;
  logic [23:0] res_o;
  logic [2:0]  ovf_o;
  logic        busy_o;
  logic [3:0]  op_cnt_o;

  vec_add_sched #(
    .LANE_W (8),
    .LANES  (3),
    .CNT_W  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_i),
    .a0_i     (a0_i),
    .b0_i     (b0_i),
    .a1_i     (a1_i),
    .b1_i     (b1_i),
    .ack_o    (ack_o),
    .res_o    (res_o),
    .ovf_o    (ovf_o),
    .busy_o   (busy_o),
    .op_cnt_o (op_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ack;
    logic [23:0] res;
    logic [2:0]  ovf;
    logic [3:0]  cnt;
  } exp_t;

  typedef struct packed {
    logic [1:0]  req;
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] res;
    logic [2:0]  ovf;
  } vec_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] m_cnt  = 4'd0;
  bit         seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [23:0] a, input logic [23:0] b,
                                output logic [23:0] r, output logic [2:0] o);
    logic [8:0] s;
    for (int i = 0; i < 3; i++) begin
      s = {1'b0, a[8*i +: 8]} + {1'b0, b[8*i +: 8]};
      o[i] = s[8];
`ifdef VEC_ADD_SAT_EN
      r[8*i +: 8] = s[8] ? 8'hFF : s[7:0];
`else
      r[8*i +: 8] = s[7:0];
`endif
    end
  endfunction

  // Advance one cycle, sample #1 after the edge, and score any ack seen.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    seen = 1'b0;
    if (ack_o != 2'b00) begin
      seen = 1'b1;
      check("ack_onehot", 32'($countones(ack_o)), 32'd1);
      if (sb.size() == 0) begin
        check("unexpected_ack", {30'd0, ack_o}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack",    {30'd0, ack_o},    {30'd0, e.ack});
        check("res",    {8'd0, res_o},     {8'd0, e.res});
        check("ovf",    {29'd0, ovf_o},    {29'd0, e.ovf});
        check("op_cnt", {28'd0, op_cnt_o}, {28'd0, e.cnt});
      end
    end
  endtask

  task automatic push(input logic [1:0] ack, input logic [23:0] res, input logic [2:0] ovf);
    m_cnt = m_cnt + 4'd1;
    sb.push_back({ack, res, ovf, m_cnt});
  endtask

  // One single-requester operation; optional operand change once EXEC is reached.
  task automatic do_op(input logic [1:0] req, input logic [23:0] a, input logic [23:0] b,
                       input logic [23:0] eres, input logic [2:0] eovf, input bit chg);
    int lat;
    a0_i = 24'($urandom()); b0_i = 24'($urandom());
    a1_i = 24'($urandom()); b1_i = 24'($urandom());
    if (req == 2'b10) begin a1_i = a; b1_i = b; end
    else              begin a0_i = a; b0_i = b; end
    req_i = req;
    push(req, eres, eovf);
    tick();  // IDLE sample edge
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      tick();
      if (i == 1) begin
        check("busy", {31'd0, busy_o}, 32'd1);
        if (chg) begin
          if (req == 2'b10) a1_i = a ^ 24'h5A5A5A;
          else              a0_i = a ^ 24'h5A5A5A;
        end
      end
      if (seen) lat = i;
    end
    check("latency", 32'(lat), 32'd3);
    req_i = 2'b00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_i = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
    m_cnt = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[8];
    logic [23:0] r, sa0, sb0, sa1, sb1, r0, r1;
    logic [2:0]  o, o0, o1;
    logic [1:0]  order[3];
    int          n;

    req_i = 2'b00;
    a0_i = '0; b0_i = '0; a1_i = '0; b1_i = '0;
    seen = 1'b0;

    tbl[0] = {2'b01, 24'h786E82, 24'h645A50, 24'hDCC8D2, 3'b000};
`ifdef VEC_ADD_SAT_EN
    tbl[1] = {2'b10, 24'hFF0180, 24'h010180, 24'hFF02FF, 3'b101};
    tbl[2] = {2'b01, 24'hFFFFFF, 24'h010101, 24'hFFFFFF, 3'b111};
`else
    tbl[1] = {2'b10, 24'hFF0180, 24'h010180, 24'h000200, 3'b101};
    tbl[2] = {2'b01, 24'hFFFFFF, 24'h010101, 24'h000000, 3'b111};
`endif
    tbl[3] = {2'b10, 24'h000000, 24'h000000, 24'h000000, 3'b000};
    tbl[4] = {2'b01, 24'h7F7F7F, 24'h808080, 24'hFFFFFF, 3'b000};
    for (int i = 5; i < 8; i++) begin
      tbl[i].req = (i % 2 == 1) ? 2'b10 : 2'b01;
      tbl[i].a   = 24'($urandom());
      tbl[i].b   = 24'($urandom());
      model(tbl[i].a, tbl[i].b, r, o);
      tbl[i].res = r;
      tbl[i].ovf = o;
    end

    // Reset state.
    do_reset();
    check("rst_ack",  {30'd0, ack_o},    32'd0);
    check("rst_res",  {8'd0, res_o},     32'd0);
    check("rst_ovf",  {29'd0, ovf_o},    32'd0);
    check("rst_busy", {31'd0, busy_o},   32'd0);
    check("rst_cnt",  {28'd0, op_cnt_o}, 32'd0);

    // Table of single-requester operations.
    foreach (tbl[i]) do_op(tbl[i].req, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].ovf, 1'b0);

    // Operand change after the LOAD edge must not affect the result.
    do_op(2'b01, 24'h102030, 24'h010203, 24'h112233, 3'b000, 1'b1);
    do_op(2'b10, 24'h0A0B0C, 24'h101010, 24'h1A1B1C, 3'b000, 1'b1);

    // Simultaneous requests from a fresh reset: round robin 01, 10, 01.
    do_reset();
    sa0 = 24'h112233; sb0 = 24'h010101; sa1 = 24'hF0F0F0; sb1 = 24'h202020;
    model(sa0, sb0, r0, o0);
    model(sa1, sb1, r1, o1);
    push(2'b01, r0, o0);
    push(2'b10, r1, o1);
    push(2'b01, r0, o0);
    a0_i = sa0; b0_i = sb0; a1_i = sa1; b1_i = sb1;
    req_i = 2'b11;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (seen && n < 3) begin order[n] = ack_o; n++; end
    end
    req_i = 2'b00;
    check("sim_acks", 32'(n), 32'd3);
    check("sim_order0", {30'd0, order[0]}, 32'd1);
    check("sim_order1", {30'd0, order[1]}, 32'd2);
    check("sim_order2", {30'd0, order[2]}, 32'd1);
    tick();
    check("sim_cnt", {28'd0, op_cnt_o}, 32'd3);

    // Reset during EXEC drops the operation with no ack.
    a0_i = 24'h010101; b0_i = 24'h020202; req_i = 2'b01;
    tick();  // IDLE sample
    tick();  // LOAD edge, now in EXEC
    rst_n = 1'b0;
    tick();
    check("mid_busy", {31'd0, busy_o},   32'd0);
    check("mid_ack",  {30'd0, ack_o},    32'd0);
    check("mid_res",  {8'd0, res_o},     32'd0);
    check("mid_ovf",  {29'd0, ovf_o},    32'd0);
    check("mid_cnt",  {28'd0, op_cnt_o}, 32'd0);
    rst_n = 1'b1;
    req_i = 2'b00;
    m_cnt = 4'd0;
    for (int i = 0; i < 8; i++) tick();

    // Counter wrap: 16 operations return a 4-bit counter to 0.
    for (int i = 0; i < 16; i++) begin
      do_op(2'b01, 24'(i), 24'h000001, 24'(i + 1), 3'b000, 1'b0);
      if (i == 14) check("cnt_15", {28'd0, op_cnt_o}, 32'd15);
    end
    check("cnt_wrap", {28'd0, op_cnt_o}, 32'd0);

    tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
